// File: rtl/invader_pkg.sv
// Shared definitions for the invader fleet sequencer.
//  state_t : sequencer states (encoding is exported on fsm_state for the HUD)
//  dir_t   : horizontal march direction
//  DEF_*   : default playfield geometry and pacing constants
package invader_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_MARCH   = 3'd2,
    S_STEP    = 3'd3,
    S_DESCEND = 3'd4,
    S_CLEAR   = 3'd5,
    S_OVER    = 3'd6
  } state_t;

  typedef enum logic {
    DIR_RIGHT = 1'b0,
    DIR_LEFT  = 1'b1
  } dir_t;

  // Width of all pixel coordinates and edge arithmetic.
  localparam int unsigned POS_W = 11;

  localparam int unsigned DEF_COLS        = 8;
  localparam int unsigned DEF_ROWS        = 4;
  localparam int unsigned DEF_X_MIN       = 150;
  localparam int unsigned DEF_X_MAX       = 776;
  localparam int unsigned DEF_Y_START     = 55;
  localparam int unsigned DEF_Y_LIMIT     = 470;
  localparam int unsigned DEF_COL_PITCH   = 48;
  localparam int unsigned DEF_ROW_PITCH   = 32;
  localparam int unsigned DEF_ALIEN_W     = 32;
  localparam int unsigned DEF_ALIEN_H     = 16;
  localparam int unsigned DEF_STEP_X      = 8;
  localparam int unsigned DEF_STEP_Y      = 16;
  localparam int unsigned DEF_BASE_PERIOD = 34;
  localparam int unsigned DEF_MIN_PERIOD  = 2;

endpackage

// File: rtl/fleet_extent.sv
// Combinational extent finder for the alive fleet.
//  alive_mask : ROWS*COLS alive bits, index = row*COLS + col
//  lcol       : leftmost column holding any alive invader
//  rcol       : rightmost column holding any alive invader
//  lrow       : lowest on-screen row (highest row index) holding any alive invader
//  any_alive  : at least one invader alive
// Extents are 0 when the mask is empty; callers gate on any_alive.
module fleet_extent
  import invader_pkg::*;
#(
  parameter int unsigned COLS = DEF_COLS,
  parameter int unsigned ROWS = DEF_ROWS,
  localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic [ROWS*COLS-1:0] alive_mask,
  output logic [CW-1:0]        lcol,
  output logic [CW-1:0]        rcol,
  output logic [RW-1:0]        lrow,
  output logic                 any_alive
);

  logic [COLS-1:0] col_any;
  logic [ROWS-1:0] row_any;

  always_comb begin
    col_any = '0;
    row_any = '0;
    for (int unsigned r = 0; r < ROWS; r++) begin
      for (int unsigned c = 0; c < COLS; c++) begin
        col_any[c] = col_any[c] | alive_mask[r*COLS + c];
        row_any[r] = row_any[r] | alive_mask[r*COLS + c];
      end
    end
  end

  // Ascending scans where the last hit wins: rcol/lrow pick the highest
  // index, lcol scans from the top down so it ends on the lowest index.
  always_comb begin
    lcol = '0;
    rcol = '0;
    lrow = '0;
    for (int unsigned i = 0; i < COLS; i++) begin
      if (col_any[i]) rcol = CW'(i);
      if (col_any[COLS-1-i]) lcol = CW'(COLS-1-i);
    end
    for (int unsigned i = 0; i < ROWS; i++) begin
      if (row_any[i]) lrow = RW'(i);
    end
  end

  assign any_alive = |alive_mask;

endmodule

// File: rtl/invader_march_ctrl.sv
// Invader fleet sequencer: paces the march on frame ticks, steps fleet_x,
// descends and reverses at the playfield edges, tracks the alive mask and
// handles kill requests from the shot logic.
//  clk, reset   : clock; asynchronous active-low reset
//  start        : 1-cycle pulse, new game (from IDLE or OVER)
//  frame_tick   : 1-cycle pulse per VGA frame
//  kill_valid   : kill request, held until kill_ack
//  kill_row/col : target invader of the kill request
//  kill_ack     : 1-cycle accept of the current kill request
//  score_inc    : 1-cycle pulse when a live invader was destroyed
//  fleet_x/y    : pixel origin of column 0 / row 0
//  alive_mask   : 1 = invader alive, index row*COLS+col
//  alive_count  : number of set bits in alive_mask
//  fsm_state    : current state_t encoding
//  game_over    : high while in OVER
// Build option: define INVADER_SPEEDUP_EN to shorten the step interval as
// the fleet thins (MIN_PERIOD + alive_count - 1 frames); otherwise the
// interval is a constant BASE_PERIOD frames.
module invader_march_ctrl
  import invader_pkg::*;
#(
  parameter int unsigned COLS        = DEF_COLS,
  parameter int unsigned ROWS        = DEF_ROWS,
  parameter int unsigned X_MIN       = DEF_X_MIN,
  parameter int unsigned X_MAX       = DEF_X_MAX,
  parameter int unsigned Y_START     = DEF_Y_START,
  parameter int unsigned Y_LIMIT     = DEF_Y_LIMIT,
  parameter int unsigned COL_PITCH   = DEF_COL_PITCH,
  parameter int unsigned ROW_PITCH   = DEF_ROW_PITCH,
  parameter int unsigned ALIEN_W     = DEF_ALIEN_W,
  parameter int unsigned ALIEN_H     = DEF_ALIEN_H,
  parameter int unsigned STEP_X      = DEF_STEP_X,
  parameter int unsigned STEP_Y      = DEF_STEP_Y,
  parameter int unsigned BASE_PERIOD = DEF_BASE_PERIOD,
  parameter int unsigned MIN_PERIOD  = DEF_MIN_PERIOD,
  localparam int unsigned N     = ROWS * COLS,
  localparam int unsigned CW    = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int unsigned RW    = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int unsigned CNT_W = $clog2(N + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             frame_tick,
  input  logic             kill_valid,
  input  logic [RW-1:0]    kill_row,
  input  logic [CW-1:0]    kill_col,
  output logic             kill_ack,
  output logic             score_inc,
  output logic [10:0]      fleet_x,
  output logic [10:0]      fleet_y,
  output logic [N-1:0]     alive_mask,
  output logic [CNT_W-1:0] alive_count,
  output logic [2:0]       fsm_state,
  output logic             game_over
);

  localparam int unsigned SPD_MAX = MIN_PERIOD + N - 1;
  localparam int unsigned PER_MAX = (BASE_PERIOD > SPD_MAX) ? BASE_PERIOD : SPD_MAX;
  localparam int unsigned PER_W   = $clog2(PER_MAX + 1);
  localparam int unsigned IDX_W   = (N > 1) ? $clog2(N) : 1;

`ifdef INVADER_SPEEDUP_EN
  localparam int unsigned LOAD_PERIOD = SPD_MAX;
`else
  localparam int unsigned LOAD_PERIOD = BASE_PERIOD;
`endif

  localparam logic [POS_W-1:0] X_MIN_P     = POS_W'(X_MIN);
  localparam logic [POS_W-1:0] X_MAX_P     = POS_W'(X_MAX);
  localparam logic [POS_W-1:0] Y_START_P   = POS_W'(Y_START);
  localparam logic [POS_W-1:0] Y_LIMIT_P   = POS_W'(Y_LIMIT);
  localparam logic [POS_W-1:0] COL_PITCH_P = POS_W'(COL_PITCH);
  localparam logic [POS_W-1:0] ROW_PITCH_P = POS_W'(ROW_PITCH);
  localparam logic [POS_W-1:0] ALIEN_W_P   = POS_W'(ALIEN_W);
  localparam logic [POS_W-1:0] ALIEN_H_P   = POS_W'(ALIEN_H);
  localparam logic [POS_W-1:0] STEP_X_P    = POS_W'(STEP_X);
  localparam logic [POS_W-1:0] STEP_Y_P    = POS_W'(STEP_Y);

  state_t              state_q,       state_d;
  dir_t                dir_q,         dir_d;
  logic [POS_W-1:0]    fleet_x_q,     fleet_x_d;
  logic [POS_W-1:0]    fleet_y_q,     fleet_y_d;
  logic [PER_W-1:0]    frame_cnt_q,   frame_cnt_d;
  logic [PER_W-1:0]    period_q,      period_d;
  logic [N-1:0]        alive_mask_q,  alive_mask_d;
  logic [CNT_W-1:0]    alive_count_q, alive_count_d;
  logic                kill_busy_q,   kill_busy_d;
  logic                kill_ack_q,    kill_ack_d;
  logic                score_inc_q,   score_inc_d;

  logic [CW-1:0]       lcol, rcol;
  logic [RW-1:0]       lrow;
  logic                any_alive;

  fleet_extent #(
    .COLS (COLS),
    .ROWS (ROWS)
  ) u_extent (
    .alive_mask (alive_mask_q),
    .lcol       (lcol),
    .rcol       (rcol),
    .lrow       (lrow),
    .any_alive  (any_alive)
  );

  // Edge tests are done on the pre-move position, so a left step is only
  // taken when it cannot push fleet_x below X_MIN (no unsigned wrap).
  logic [POS_W-1:0] right_edge, left_edge, y_desc, bottom;
  logic             step_blocked, over_limit;

  assign right_edge   = fleet_x_q + POS_W'(rcol) * COL_PITCH_P + ALIEN_W_P;
  assign left_edge    = fleet_x_q + POS_W'(lcol) * COL_PITCH_P;
  assign step_blocked = (dir_q == DIR_RIGHT) ? (right_edge + STEP_X_P > X_MAX_P)
                                             : (left_edge < X_MIN_P + STEP_X_P);
  assign y_desc       = fleet_y_q + STEP_Y_P;
  assign bottom       = y_desc + POS_W'(lrow) * ROW_PITCH_P + ALIEN_H_P;
  assign over_limit   = (bottom >= Y_LIMIT_P);

  // Next interval length, latched whenever frame_cnt restarts.
  logic [PER_W-1:0] step_period;
`ifdef INVADER_SPEEDUP_EN
  assign step_period = PER_W'(MIN_PERIOD) + PER_W'(alive_count_q) - PER_W'(1);
`else
  assign step_period = PER_W'(BASE_PERIOD);
`endif

  // Kill handshake: a request is accepted on the first cycle kill_valid is
  // seen after having been low, so a held request is acked exactly once.
  logic [31:0]      kill_lin;
  logic [IDX_W-1:0] kill_idx;
  logic             kill_accept, kill_live, kill_hit;

  assign kill_lin    = 32'(kill_row) * COLS + 32'(kill_col);
  assign kill_idx    = IDX_W'(kill_lin);
  assign kill_accept = kill_valid & ~kill_busy_q;
  assign kill_live   = (state_q == S_MARCH) || (state_q == S_STEP) || (state_q == S_DESCEND);
  assign kill_hit    = kill_accept & kill_live & (kill_lin < N) & alive_mask_q[kill_idx];

  always_comb begin
    state_d       = state_q;
    dir_d         = dir_q;
    fleet_x_d     = fleet_x_q;
    fleet_y_d     = fleet_y_q;
    frame_cnt_d   = frame_cnt_q;
    period_d      = period_q;
    alive_mask_d  = alive_mask_q;
    alive_count_d = alive_count_q;
    kill_busy_d   = kill_valid;
    kill_ack_d    = kill_accept;
    score_inc_d   = kill_hit;

    // STEP/DESCEND read the registered mask, so a kill landing in the same
    // cycle only affects the following step.
    if (kill_hit) begin
      alive_mask_d[kill_idx] = 1'b0;
      alive_count_d          = alive_count_q - CNT_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_LOAD;
      end
      S_LOAD: begin
        alive_mask_d  = '1;
        alive_count_d = CNT_W'(N);
        fleet_x_d     = X_MIN_P;
        fleet_y_d     = Y_START_P;
        dir_d         = DIR_RIGHT;
        frame_cnt_d   = '0;
        period_d      = PER_W'(LOAD_PERIOD);
        state_d       = S_MARCH;
      end
      S_MARCH: begin
        if (!any_alive) begin
          state_d = S_CLEAR;
        end else if (frame_tick) begin
          if (frame_cnt_q == period_q - PER_W'(1)) begin
            frame_cnt_d = '0;
            period_d    = step_period;
            state_d     = S_STEP;
          end else begin
            frame_cnt_d = frame_cnt_q + PER_W'(1);
          end
        end
      end
      S_STEP: begin
        if (!any_alive) begin
          state_d = S_CLEAR;
        end else if (step_blocked) begin
          state_d = S_DESCEND;
        end else begin
          fleet_x_d = (dir_q == DIR_RIGHT) ? fleet_x_q + STEP_X_P : fleet_x_q - STEP_X_P;
          state_d   = S_MARCH;
        end
      end
      S_DESCEND: begin
        if (!any_alive) begin
          state_d = S_CLEAR;
        end else begin
          fleet_y_d = y_desc;
          dir_d     = (dir_q == DIR_RIGHT) ? DIR_LEFT : DIR_RIGHT;
          state_d   = over_limit ? S_OVER : S_MARCH;
        end
      end
      S_CLEAR: begin
        if (frame_tick) state_d = S_LOAD;
      end
      S_OVER: begin
        if (start) state_d = S_LOAD;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      dir_q         <= DIR_RIGHT;
      fleet_x_q     <= X_MIN_P;
      fleet_y_q     <= Y_START_P;
      frame_cnt_q   <= '0;
      period_q      <= PER_W'(LOAD_PERIOD);
      alive_mask_q  <= '0;
      alive_count_q <= '0;
      kill_busy_q   <= 1'b0;
      kill_ack_q    <= 1'b0;
      score_inc_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      dir_q         <= dir_d;
      fleet_x_q     <= fleet_x_d;
      fleet_y_q     <= fleet_y_d;
      frame_cnt_q   <= frame_cnt_d;
      period_q      <= period_d;
      alive_mask_q  <= alive_mask_d;
      alive_count_q <= alive_count_d;
      kill_busy_q   <= kill_busy_d;
      kill_ack_q    <= kill_ack_d;
      score_inc_q   <= score_inc_d;
    end
  end

  assign kill_ack    = kill_ack_q;
  assign score_inc   = score_inc_q;
  assign fleet_x     = fleet_x_q;
  assign fleet_y     = fleet_y_q;
  assign alive_mask  = alive_mask_q;
  assign alive_count = alive_count_q;
  assign fsm_state   = state_q;
  assign game_over   = (state_q == S_OVER);

endmodule

// File: tb/tb_invader_march_ctrl.sv
// Directed bench for invader_march_ctrl (default build, fixed 34-frame pace).
module tb_invader_march_ctrl;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_LOAD    = 3'd1;
  localparam logic [2:0] ST_MARCH   = 3'd2;
  localparam logic [2:0] ST_STEP    = 3'd3;
  localparam logic [2:0] ST_DESCEND = 3'd4;
  localparam logic [2:0] ST_CLEAR   = 3'd5;
  localparam logic [2:0] ST_OVER    = 3'd6;

  logic        clk = 1'b0;
  logic        reset, start, frame_tick, kill_valid;
  logic [1:0]  kill_row;
  logic [2:0]  kill_col;
  logic        kill_ack, score_inc;
  logic [10:0] fleet_x, fleet_y;
  logic [31:0] alive_mask;
  logic [5:0]  alive_count;
  logic [2:0]  fsm_state;
  logic        game_over;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  invader_march_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .frame_tick  (frame_tick),
    .kill_valid  (kill_valid),
    .kill_row    (kill_row),
    .kill_col    (kill_col),
    .kill_ack    (kill_ack),
    .score_inc   (score_inc),
    .fleet_x     (fleet_x),
    .fleet_y     (fleet_y),
    .alive_mask  (alive_mask),
    .alive_count (alive_count),
    .fsm_state   (fsm_state),
    .game_over   (game_over)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Holds frame_tick high until fsm_state reaches s or the budget runs out.
  task automatic wait_state(input logic [2:0] s, input int unsigned budget, input string tag);
    int unsigned n;
    n = 0;
    frame_tick = 1'b1;
    do begin
      cyc();
      n++;
    end while (fsm_state !== s && n < budget);
    frame_tick = 1'b0;
    chk(tag, 32'(fsm_state), 32'(s));
  endtask

  // Full request/ack exchange; the request is held one cycle past the ack.
  task automatic do_kill(input int unsigned r, input int unsigned c,
                         input int unsigned exp_score, input int unsigned exp_cnt);
    frame_tick = 1'b0;
    kill_row   = 2'(r);
    kill_col   = 3'(c);
    kill_valid = 1'b1;
    cyc();
    chk("kill_ack", 32'(kill_ack), 1);
    chk("score_inc", 32'(score_inc), exp_score);
    chk("alive_count_kill", 32'(alive_count), exp_cnt);
    cyc();
    chk("kill_ack_held", 32'(kill_ack), 0);
    kill_valid = 1'b0;
    cyc();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; start = 1'b0; frame_tick = 1'b0;
    kill_valid = 1'b0; kill_row = '0; kill_col = '0;
    cyc(); cyc();

    // Reset values
    chk("rst_state", 32'(fsm_state), 32'(ST_IDLE));
    chk("rst_fleet_x", 32'(fleet_x), 150);
    chk("rst_fleet_y", 32'(fleet_y), 55);
    chk("rst_mask", alive_mask, 0);
    chk("rst_count", 32'(alive_count), 0);
    chk("rst_ack", 32'(kill_ack), 0);
    chk("rst_score", 32'(score_inc), 0);
    chk("rst_game_over", 32'(game_over), 0);
    reset = 1'b1;
    cyc();

    // Kill in IDLE: acked, no effect
    do_kill(0, 0, 0, 0);
    chk("idle_kill_mask", alive_mask, 0);

    // Start, load, 34 ticks -> one step right
    start = 1'b1; cyc();
    chk("load_state", 32'(fsm_state), 32'(ST_LOAD));
    start = 1'b0; cyc();
    chk("march_state", 32'(fsm_state), 32'(ST_MARCH));
    chk("load_mask", alive_mask, 32'hFFFF_FFFF);
    chk("load_count", 32'(alive_count), 32);
    chk("load_fleet_x", 32'(fleet_x), 150);
    chk("load_fleet_y", 32'(fleet_y), 55);
    repeat (33) begin
      frame_tick = 1'b1; cyc();
      frame_tick = 1'b0; cyc();
    end
    chk("tick33_state", 32'(fsm_state), 32'(ST_MARCH));
    chk("tick33_fleet_x", 32'(fleet_x), 150);
    frame_tick = 1'b1; cyc();
    frame_tick = 1'b0;
    chk("tick34_state", 32'(fsm_state), 32'(ST_STEP));
    cyc();
    chk("step1_state", 32'(fsm_state), 32'(ST_MARCH));
    chk("step1_fleet_x", 32'(fleet_x), 158);
    chk("step1_count", 32'(alive_count), 32);
    chk("step1_game_over", 32'(game_over), 0);

    // Kill (2,5) = bit 21, then the same target again
    do_kill(2, 5, 1, 31);
    chk("kill21_mask", alive_mask, 32'hFFDF_FFFF);
    do_kill(2, 5, 0, 31);
    chk("kill21_again_mask", alive_mask, 32'hFFDF_FFFF);

    // March right until the edge blocks: 406+7*48+32+8 = 782 > 776
    wait_state(ST_DESCEND, 3000, "wait_descend_right");
    chk("edge_fleet_x", 32'(fleet_x), 406);
    chk("edge_fleet_y", 32'(fleet_y), 55);
    cyc();
    chk("desc1_state", 32'(fsm_state), 32'(ST_MARCH));
    chk("desc1_fleet_y", 32'(fleet_y), 71);
    chk("desc1_fleet_x", 32'(fleet_x), 406);
    wait_state(ST_STEP, 100, "wait_step_left");
    cyc();
    chk("left_step_fleet_x", 32'(fleet_x), 398);

    // Asynchronous reset mid-MARCH, checked before any clock edge
    chk("pre_areset_state", 32'(fsm_state), 32'(ST_MARCH));
    reset = 1'b0;
    #2;
    chk("areset_state", 32'(fsm_state), 32'(ST_IDLE));
    chk("areset_fleet_x", 32'(fleet_x), 150);
    chk("areset_fleet_y", 32'(fleet_y), 55);
    chk("areset_mask", alive_mask, 0);
    chk("areset_count", 32'(alive_count), 0);
    chk("areset_game_over", 32'(game_over), 0);
    cyc();
    reset = 1'b1;
    cyc();

    // Column 7 gone: right edge 48 px narrower, descent at 454
    start = 1'b1; cyc();
    start = 1'b0; cyc();
    for (int r = 0; r < 4; r++) do_kill(r, 7, 1, 31 - r);
    chk("col7_mask", alive_mask, 32'h7F7F_7F7F);
    wait_state(ST_DESCEND, 4000, "wait_descend_col7");
    chk("col7_edge_fleet_x", 32'(fleet_x), 454);
    cyc();
    chk("col7_desc_fleet_y", 32'(fleet_y), 71);

    // Only row 0 alive: 25th descent goes 439 -> 455, 455+16 >= 470
    reset = 1'b0; cyc();
    reset = 1'b1; cyc();
    start = 1'b1; cyc();
    start = 1'b0; cyc();
    for (int r = 1; r < 4; r++)
      for (int c = 0; c < 8; c++)
        do_kill(r, c, 1, 31 - (r - 1) * 8 - c);
    chk("row0_mask", alive_mask, 32'h0000_00FF);
    chk("row0_count", 32'(alive_count), 8);
    repeat (24) wait_state(ST_DESCEND, 3000, "wait_descend_n");
    wait_state(ST_DESCEND, 3000, "wait_descend_last");
    chk("last_desc_fleet_y", 32'(fleet_y), 439);
    chk("last_desc_fleet_x", 32'(fleet_x), 406);
    cyc();
    chk("over_state", 32'(fsm_state), 32'(ST_OVER));
    chk("over_fleet_y", 32'(fleet_y), 455);
    chk("over_game_over", 32'(game_over), 1);
    repeat (3) begin
      frame_tick = 1'b1; cyc();
    end
    frame_tick = 1'b0; cyc();
    chk("over_frozen_state", 32'(fsm_state), 32'(ST_OVER));
    chk("over_frozen_fleet_y", 32'(fleet_y), 455);
    chk("over_frozen_fleet_x", 32'(fleet_x), 406);
    start = 1'b1; cyc();
    chk("restart_load", 32'(fsm_state), 32'(ST_LOAD));
    start = 1'b0; cyc();
    chk("restart_state", 32'(fsm_state), 32'(ST_MARCH));
    chk("restart_fleet_y", 32'(fleet_y), 55);
    chk("restart_fleet_x", 32'(fleet_x), 150);
    chk("restart_count", 32'(alive_count), 32);
    chk("restart_game_over", 32'(game_over), 0);

    // Kill every invader -> CLEAR, next tick -> LOAD -> fresh wave
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 8; c++)
        do_kill(r, c, 1, 31 - r * 8 - c);
    chk("clear_state", 32'(fsm_state), 32'(ST_CLEAR));
    chk("clear_mask", alive_mask, 0);
    cyc(); cyc();
    chk("clear_wait_state", 32'(fsm_state), 32'(ST_CLEAR));
    frame_tick = 1'b1; cyc();
    frame_tick = 1'b0;
    chk("clear_to_load", 32'(fsm_state), 32'(ST_LOAD));
    cyc();
    chk("wave2_state", 32'(fsm_state), 32'(ST_MARCH));
    chk("wave2_mask", alive_mask, 32'hFFFF_FFFF);
    chk("wave2_count", 32'(alive_count), 32);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
